// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - dual-issue pair buffer with scoreboard interlocks
//
// Holds one decoded instruction pair and issues each slot to the even or odd
// pipe. Issue is in order. A per-register countdown scoreboard blocks RAW
// and WAW hazards. Decode is back-pressured while a pair is pending, and
// stall cycles are counted.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   dec_valid/dec_ready   decode handshake; a pair is taken when both are high
//   flush                 drops the buffered pair and blocks acceptance
//   i1_* / i2_*           older / younger slot: valid, word, pipe, wr, rt,
//                         ra/rb/rc, rd_mask {ra,rb,rc}, lat
//   even_valid/even_inst  registered issue to the even pipe
//   odd_valid/odd_inst    registered issue to the odd pipe
//   stall_cycles          saturating count of cycles with a pending, non-issuing pair
module dual_issue_scheduler #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4,
  parameter int STALL_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic               flush,
  input  logic               i1_valid,
  input  logic [31:0]        i1_word,
  input  logic               i1_pipe,
  input  logic               i1_wr,
  input  logic [6:0]         i1_rt,
  input  logic [6:0]         i1_ra,
  input  logic [6:0]         i1_rb,
  input  logic [6:0]         i1_rc,
  input  logic [2:0]         i1_rd_mask,
  input  logic [LAT_W-1:0]   i1_lat,
  input  logic               i2_valid,
  input  logic [31:0]        i2_word,
  input  logic               i2_pipe,
  input  logic               i2_wr,
  input  logic [6:0]         i2_rt,
  input  logic [6:0]         i2_ra,
  input  logic [6:0]         i2_rb,
  input  logic [6:0]         i2_rc,
  input  logic [2:0]         i2_rd_mask,
  input  logic [LAT_W-1:0]   i2_lat,
  output logic               even_valid,
  output logic [31:0]        even_inst,
  output logic               odd_valid,
  output logic [31:0]        odd_inst,
  output logic [STALL_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {EMPTY, FULL, HALF} state_t;

  state_t state, state_n;

  logic [31:0]      s1_word, s2_word;
  logic             s1_pipe, s2_pipe, s1_wr, s2_wr, s2_done;
  logic [6:0]       s1_rt, s1_ra, s1_rb, s1_rc;
  logic [6:0]       s2_rt, s2_ra, s2_rb, s2_rc;
  logic [2:0]       s1_mask, s2_mask;
  logic [LAT_W-1:0] s1_lat, s2_lat;
  logic [LAT_W-1:0] sb [NUM_REGS];

  logic blk1, blk2, pair_hz, iss1, iss2, drained, accept;

  // Hazard checks against the scoreboard and between the two slots.
  always_comb begin
    blk1 = (s1_mask[2] && sb[s1_ra] != '0) || (s1_mask[1] && sb[s1_rb] != '0) ||
           (s1_mask[0] && sb[s1_rc] != '0) || (s1_wr && sb[s1_rt] != '0);
    blk2 = (s2_mask[2] && sb[s2_ra] != '0) || (s2_mask[1] && sb[s2_rb] != '0) ||
           (s2_mask[0] && sb[s2_rc] != '0) || (s2_wr && sb[s2_rt] != '0);
    // The scoreboard does not yet see slot1's write in the cycle it issues,
    // so a same-cycle pair must also be checked directly against slot1.
    pair_hz = (s1_pipe == s2_pipe) ||
              (s1_wr && ((s2_mask[2] && s2_ra == s1_rt) ||
                         (s2_mask[1] && s2_rb == s1_rt) ||
                         (s2_mask[0] && s2_rc == s1_rt))) ||
              (s1_wr && s2_wr && s1_rt == s2_rt);
  end

  // Issue decisions and decode handshake.
  always_comb begin
    iss1 = !flush && state == FULL && !blk1;
    iss2 = !flush && !blk2 &&
           ((state == HALF) || (state == FULL && !s2_done && iss1 && !pair_hz));
    case (state)
      FULL:    drained = iss1 && (s2_done || iss2);
      HALF:    drained = iss2;
      default: drained = 1'b0;
    endcase
    dec_ready = !flush && (state == EMPTY || drained);
    accept    = dec_valid && dec_ready;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = EMPTY;
    end else if (state == EMPTY || drained) begin
      if (accept) begin
        case ({i1_valid, i2_valid})
          2'b11, 2'b10: state_n = FULL;
          2'b01:        state_n = HALF;
          default:      state_n = EMPTY;
        endcase
      end else begin
        state_n = EMPTY;
      end
    end else if (state == FULL && iss1) begin
      state_n = HALF;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  // Pair buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_word <= '0; s1_pipe <= 1'b0; s1_wr <= 1'b0; s1_rt <= '0;
      s1_ra <= '0; s1_rb <= '0; s1_rc <= '0; s1_mask <= '0; s1_lat <= '0;
      s2_word <= '0; s2_pipe <= 1'b0; s2_wr <= 1'b0; s2_rt <= '0;
      s2_ra <= '0; s2_rb <= '0; s2_rc <= '0; s2_mask <= '0; s2_lat <= '0;
      s2_done <= 1'b0;
    end else if (accept) begin
      s1_word <= i1_word; s1_pipe <= i1_pipe; s1_wr <= i1_wr; s1_rt <= i1_rt;
      s1_ra <= i1_ra; s1_rb <= i1_rb; s1_rc <= i1_rc; s1_mask <= i1_rd_mask; s1_lat <= i1_lat;
      s2_word <= i2_word; s2_pipe <= i2_pipe; s2_wr <= i2_wr; s2_rt <= i2_rt;
      s2_ra <= i2_ra; s2_rb <= i2_rb; s2_rc <= i2_rc; s2_mask <= i2_rd_mask; s2_lat <= i2_lat;
      s2_done <= !i2_valid;
    end
  end

  // Pipe outputs. The pair hazard rule guarantees at most one issue per pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      even_valid <= 1'b0;
      even_inst  <= '0;
      odd_valid  <= 1'b0;
      odd_inst   <= '0;
    end else begin
      even_valid <= (iss1 && !s1_pipe) || (iss2 && !s2_pipe);
      odd_valid  <= (iss1 && s1_pipe) || (iss2 && s2_pipe);
      if (iss1 && !s1_pipe)      even_inst <= s1_word;
      else if (iss2 && !s2_pipe) even_inst <= s2_word;
      if (iss1 && s1_pipe)       odd_inst <= s1_word;
      else if (iss2 && s2_pipe)  odd_inst <= s2_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (state != EMPTY && !iss1 && !iss2 && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

  // Countdown scoreboard; a load from an issuing writer overrides the decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) sb[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (sb[r] != '0) sb[r] <= sb[r] - LAT_W'(1);
      end
      if (iss1 && s1_wr && s1_lat != '0) sb[s1_rt] <= s1_lat;
      if (iss2 && s2_wr && s2_lat != '0) sb[s2_rt] <= s2_lat;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - scoreboard bench for dual_issue_scheduler
module tb_dual_issue_scheduler;

  logic        clock, reset, dec_valid, dec_ready, flush;
  logic        i1_valid, i1_pipe, i1_wr, i2_valid, i2_pipe, i2_wr;
  logic [31:0] i1_word, i2_word, even_inst, odd_inst;
  logic [6:0]  i1_rt, i1_ra, i1_rb, i1_rc, i2_rt, i2_ra, i2_rb, i2_rc;
  logic [2:0]  i1_rd_mask, i2_rd_mask;
  logic [3:0]  i1_lat, i2_lat;
  logic        even_valid, odd_valid;
  logic [15:0] stall_cycles;

  dual_issue_scheduler dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready), .flush(flush),
    .i1_valid(i1_valid), .i1_word(i1_word), .i1_pipe(i1_pipe), .i1_wr(i1_wr), .i1_rt(i1_rt),
    .i1_ra(i1_ra), .i1_rb(i1_rb), .i1_rc(i1_rc), .i1_rd_mask(i1_rd_mask), .i1_lat(i1_lat),
    .i2_valid(i2_valid), .i2_word(i2_word), .i2_pipe(i2_pipe), .i2_wr(i2_wr), .i2_rt(i2_rt),
    .i2_ra(i2_ra), .i2_rb(i2_rb), .i2_rc(i2_rc), .i2_rd_mask(i2_rd_mask), .i2_lat(i2_lat),
    .even_valid(even_valid), .even_inst(even_inst), .odd_valid(odd_valid), .odd_inst(odd_inst),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] cyc;
  } exp_t;

  exp_t        even_q[$];
  exp_t        odd_q[$];
  logic [31:0] cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] a, b, c, d, p, q, s;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic push_even(input logic [31:0] w, input logic [31:0] at);
    exp_t t;
    t.word = w; t.cyc = at;
    even_q.push_back(t);
  endtask

  task automatic push_odd(input logic [31:0] w, input logic [31:0] at);
    exp_t t;
    t.word = w; t.cyc = at;
    odd_q.push_back(t);
  endtask

  // Monitor: each issue is matched against the next expected word and cycle.
  always @(negedge clock) begin
    exp_t e;
    if (even_valid) begin
      if (even_q.size() == 0) begin
        total++; bad++;
        $display("FAIL even_unexpected act=%0h req=none", even_inst);
      end else begin
        e = even_q.pop_front();
        check("even_word", {32'd0, even_inst}, {32'd0, e.word});
        check("even_cycle", {32'd0, cyc}, {32'd0, e.cyc});
      end
    end
    if (odd_valid) begin
      if (odd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL odd_unexpected act=%0h req=none", odd_inst);
      end else begin
        e = odd_q.pop_front();
        check("odd_word", {32'd0, odd_inst}, {32'd0, e.word});
        check("odd_cycle", {32'd0, cyc}, {32'd0, e.cyc});
      end
    end
  end

  task automatic set1(input logic v, input logic [31:0] w, input logic pp, input logic wr,
                      input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                      input logic [6:0] rc, input logic [2:0] m, input logic [3:0] lat);
    i1_valid = v; i1_word = w; i1_pipe = pp; i1_wr = wr; i1_rt = rt;
    i1_ra = ra; i1_rb = rb; i1_rc = rc; i1_rd_mask = m; i1_lat = lat;
  endtask

  task automatic set2(input logic v, input logic [31:0] w, input logic pp, input logic wr,
                      input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                      input logic [6:0] rc, input logic [2:0] m, input logic [3:0] lat);
    i2_valid = v; i2_word = w; i2_pipe = pp; i2_wr = wr; i2_rt = rt;
    i2_ra = ra; i2_rb = rb; i2_rc = rc; i2_rd_mask = m; i2_lat = lat;
  endtask

  // Called at a falling edge; returns the cycle count just after the accepting edge.
  task automatic accept(output logic [31:0] at);
    int n;
    n = 0;
    dec_valid = 1'b1;
    #1;
    while (!dec_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (!dec_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout act=dec_ready=0 req=1");
      at = cyc;
    end else begin
      @(posedge clock); #1;
      at = cyc;
    end
    dec_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    set1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); @(negedge clock); #1;
    check("rst_even_valid", {63'd0, even_valid}, 64'd0);
    check("rst_odd_valid", {63'd0, odd_valid}, 64'd0);
    check("rst_even_inst", {32'd0, even_inst}, 64'd0);
    check("rst_odd_inst", {32'd0, odd_inst}, 64'd0);
    check("rst_stall", {48'd0, stall_cycles}, 64'd0);
    check("rst_dec_ready", {63'd0, dec_ready}, 64'd1);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    // Independent pair: r5 lat 6 (even), r9 lat 2 (odd), both issue next cycle.
    set1(1, 32'hA000_0005, 0, 1, 5, 1, 2, 3, 3'b111, 6);
    set2(1, 32'hB000_0009, 1, 1, 9, 0, 0, 0, 3'b000, 2);
    accept(a);
    push_even(32'hA000_0005, a + 1);
    push_odd(32'hB000_0009, a + 1);
    @(negedge clock);
    check("a_ready", {63'd0, dec_ready}, 64'd1);
    // Readers of r9 and r5 pin the loaded counter values: issue at +3 and +7.
    set1(1, 32'hC000_0001, 0, 0, 0, 0, 9, 0, 3'b010, 0);
    set2(1, 32'hD000_0002, 1, 0, 0, 5, 0, 0, 3'b100, 0);
    accept(a);
    push_even(32'hC000_0001, a + 3);
    push_odd(32'hD000_0002, a + 7);
    repeat (12) @(negedge clock);
    check("a_stall", {48'd0, stall_cycles}, 64'd5);

    // Both even: back-to-back issue through HALF, no stall.
    set1(1, 32'hE000_0014, 0, 1, 20, 0, 0, 0, 3'b000, 3);
    set2(1, 32'hE000_0015, 0, 1, 21, 0, 0, 0, 3'b000, 1);
    accept(b);
    push_even(32'hE000_0014, b + 1);
    push_even(32'hE000_0015, b + 2);
    @(negedge clock);
    check("b_ready_full", {63'd0, dec_ready}, 64'd0);
    @(negedge clock);
    check("b_ready_half", {63'd0, dec_ready}, 64'd1);
    repeat (4) @(negedge clock);
    check("b_stall", {48'd0, stall_cycles}, 64'd5);

    // Intra-pair RAW on r10 lat 2: i2 issues three cycles after i1.
    set1(1, 32'hF000_000A, 0, 1, 10, 0, 0, 0, 3'b000, 2);
    set2(1, 32'h1000_000B, 1, 1, 11, 10, 0, 0, 3'b100, 1);
    accept(c);
    push_even(32'hF000_000A, c + 1);
    push_odd(32'h1000_000B, c + 4);
    @(negedge clock);
    check("c_ready_pair", {63'd0, dec_ready}, 64'd0);
    @(negedge clock);
    check("c_ready_stall1", {63'd0, dec_ready}, 64'd0);
    @(negedge clock);
    check("c_ready_stall2", {63'd0, dec_ready}, 64'd0);
    @(negedge clock);
    check("c_ready_issue", {63'd0, dec_ready}, 64'd1);
    repeat (3) @(negedge clock);
    check("c_stall", {48'd0, stall_cycles}, 64'd7);

    // Cross-pair WAW on r3 lat 4: the whole next pair waits, then issues in order.
    set1(1, 32'h2000_0003, 0, 1, 3, 0, 0, 0, 3'b000, 4);
    set2(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    accept(d);
    push_even(32'h2000_0003, d + 1);
    @(negedge clock);
    set1(1, 32'h2100_0003, 0, 1, 3, 0, 0, 0, 3'b000, 1);
    set2(1, 32'h2200_0004, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    accept(d);
    push_even(32'h2100_0003, d + 5);
    push_odd(32'h2200_0004, d + 5);
    repeat (8) @(negedge clock);
    check("d_stall", {48'd0, stall_cycles}, 64'd11);

    // Flush while blocked on r12; the pair offered during flush is dropped.
    set1(1, 32'h3000_0012, 0, 1, 12, 0, 0, 0, 3'b000, 5);
    set2(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    accept(p);
    push_even(32'h3000_0012, p + 1);
    @(negedge clock);
    set1(1, 32'h3100_0000, 0, 0, 0, 12, 0, 0, 3'b100, 0);
    set2(1, 32'h3200_0013, 1, 1, 13, 0, 0, 0, 3'b000, 1);
    accept(q);
    @(negedge clock);
    @(negedge clock);
    flush = 1'b1;
    set1(1, 32'h3300_0000, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    set2(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    dec_valid = 1'b1;
    #1;
    check("e_ready_flush", {63'd0, dec_ready}, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0; dec_valid = 1'b0;
    @(negedge clock);
    check("e_even_valid", {63'd0, even_valid}, 64'd0);
    check("e_odd_valid", {63'd0, odd_valid}, 64'd0);
    check("e_ready_empty", {63'd0, dec_ready}, 64'd1);
    // r12 kept counting through the flush: reader issues at +3.
    set1(1, 32'h3400_0000, 0, 0, 0, 12, 0, 0, 3'b100, 0);
    accept(s);
    push_even(32'h3400_0000, s + 3);
    repeat (6) @(negedge clock);

    // Reset mid-stall on r7.
    set1(1, 32'h4000_0007, 0, 1, 7, 0, 0, 0, 3'b000, 5);
    accept(p);
    push_even(32'h4000_0007, p + 1);
    @(negedge clock);
    set1(1, 32'h4100_0000, 0, 0, 0, 7, 0, 0, 3'b100, 0);
    accept(q);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("f_even_valid", {63'd0, even_valid}, 64'd0);
    check("f_odd_valid", {63'd0, odd_valid}, 64'd0);
    check("f_even_inst", {32'd0, even_inst}, 64'd0);
    check("f_odd_inst", {32'd0, odd_inst}, 64'd0);
    check("f_stall", {48'd0, stall_cycles}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    set1(1, 32'h4200_0000, 0, 0, 0, 7, 0, 0, 3'b100, 0);
    set2(1, 32'h4300_0000, 1, 0, 0, 0, 7, 0, 3'b010, 0);
    accept(a);
    push_even(32'h4200_0000, a + 1);
    push_odd(32'h4300_0000, a + 1);
    repeat (4) @(negedge clock);
    check("f_stall_after", {48'd0, stall_cycles}, 64'd0);

    repeat (3) @(negedge clock);
    check("even_q_drained", 64'(even_q.size()), 64'd0);
    check("odd_q_drained", 64'(odd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
